// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp -- single-outstanding data-memory responder for a CPU data port.
//
// Accepts one load/store at a time in IDLE, waits a fixed LATENCY clock edges,
// then presents the response in RESP until the CPU takes it. Stores commit and
// loads read the word array on the edge that enters RESP. Addresses beyond the
// array set resp_err, suppress the write and return zero data.
//
// Parameters:
//   DEPTH    number of 64-bit words (power of two, 2..1024)
//   LATENCY  rising edges from request acceptance to resp_valid (1..15)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset (also clears the word array)
//   req_valid   request present            req_ready   responder idle
//   req_we      1 = store, 0 = load        req_addr    64-bit byte address
//   req_wdata   store data
//   resp_valid  response present           resp_ready  CPU takes response
//   resp_rdata  load data (0 for stores, errors, and when not valid)
//   resp_err    access error, qualified by resp_valid
//   stall       high whenever the responder is not IDLE
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN  when defined, a non-zero req_addr[2:0] is an error;
//                        when undefined, those bits are ignored and the
//                        access acts on the containing word.
// -----------------------------------------------------------------------------
module dmem_resp #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;

  // Captured request
  logic          we_reg;
  logic [AW-1:0] idx_reg;
  logic [63:0]   wdata_reg;
  logic          err_pend_reg;

  // Registered response
  logic [63:0]   rdata_reg;
  logic          err_reg;

  // Word array; reset clears it, so it is built from plain registers.
  logic [63:0]   mem [DEPTH];

  // Request error classification, evaluated at acceptance.
  logic range_err;
  logic align_err;
  logic req_err;

  // Any set bit above the word index means the byte address is >= DEPTH*8.
  assign range_err = |req_addr[63:AW+3];

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = |req_addr[2:0];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[2:0];
  assign align_err = 1'b0;
`endif

  assign req_err = range_err | align_err;

  // The array is touched exactly on the transition WAIT -> RESP.
  logic enter_resp;
  assign enter_resp = (state_reg == WAIT) && (cnt_reg == 4'd0);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Outputs
  assign req_ready  = (state_reg == IDLE);
  assign stall      = (state_reg != IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_valid ? rdata_reg : 64'd0;
  assign resp_err   = resp_valid ? err_reg   : 1'b0;

  // State, capture, array and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      we_reg       <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= 64'd0;
      err_pend_reg <= 1'b0;
      rdata_reg    <= 64'd0;
      err_reg      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 64'd0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if ((state_reg == IDLE) && req_valid) begin
        we_reg       <= req_we;
        idx_reg      <= req_addr[3 +: AW];
        wdata_reg    <= req_wdata;
        err_pend_reg <= req_err;
      end

      if (enter_resp) begin
        err_reg <= err_pend_reg;
        if (err_pend_reg || we_reg) begin
          rdata_reg <= 64'd0;
        end else begin
          rdata_reg <= mem[idx_reg];
        end
        if (we_reg && !err_pend_reg) begin
          mem[idx_reg] <= wdata_reg;
        end
      end

      // Drop the response data once it has been taken.
      if ((state_reg == RESP) && resp_ready) begin
        rdata_reg <= 64'd0;
        err_reg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  int checks = 0;
  int errors = 0;

  dmem_resp #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] W10_INIT = 64'hDEAD_BEEF_00C0_FFEE;
  localparam logic [63:0] W_MIS    = 64'h0000_AAAA_5555_0000;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic        MIS_ERR   = 1'b1;
  localparam logic [63:0] MIS_LOAD  = 64'd0;
  localparam logic [63:0] W10_FINAL = W10_INIT;
`else
  localparam logic        MIS_ERR   = 1'b0;
  localparam logic [63:0] MIS_LOAD  = W10_INIT;
  localparam logic [63:0] W10_FINAL = W_MIS;
`endif

  typedef struct {
    string       name;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // One complete transaction with resp_ready held high.
  task automatic do_txn(input string name, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input logic exp_err);
    int edges;
    int stall_cnt;
    bit seen;
    @(negedge clk);
    chk({name, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b1;
    @(posedge clk);
    edges     = 0;
    stall_cnt = 0;
    seen      = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (stall) stall_cnt++;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: resp_valid never rose within 40 cycles", name);
    end else begin
      chk({name, ".latency"}, 64'(edges), 64'(LATENCY));
      chk({name, ".stall_cycles"}, 64'(stall_cnt), 64'(LATENCY + 1));
      chk({name, ".rdata"}, resp_rdata, exp_rdata);
      chk({name, ".err"}, 64'(resp_err), 64'(exp_err));
      $display("txn %s we=%0b addr=0x%016h rdata=0x%016h err=%0b latency=%0d",
               name, we, addr, resp_rdata, resp_err, edges);
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, ".idle_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({name, ".idle_req_ready"}, 64'(req_ready), 64'd1);
    chk({name, ".idle_stall"}, 64'(stall), 64'd0);
    chk({name, ".idle_rdata"}, resp_rdata, 64'd0);
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{"st_10",     1'b1, 64'h10,  W10_INIT,  64'd0,     1'b0};
    vecs[1]  = '{"ld_10",     1'b0, 64'h10,  64'd0,     W10_INIT,  1'b0};
    vecs[2]  = '{"ld_18",     1'b0, 64'h18,  64'd0,     64'd0,     1'b0};
    vecs[3]  = '{"ld_400",    1'b0, 64'h400, 64'd0,     64'd0,     1'b1};
    vecs[4]  = '{"st_400",    1'b1, 64'h400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
    vecs[5]  = '{"ld_00",     1'b0, 64'h0,   64'd0,     64'd0,     1'b0};
    vecs[6]  = '{"ld_13",     1'b0, 64'h13,  64'd0,     MIS_LOAD,  MIS_ERR};
    vecs[7]  = '{"st_3f8",    1'b1, 64'h3F8, 64'h1122_3344_5566_7788, 64'd0, 1'b0};
    vecs[8]  = '{"ld_3f8",    1'b0, 64'h3F8, 64'd0,     64'h1122_3344_5566_7788, 1'b0};
    vecs[9]  = '{"st_13",     1'b1, 64'h13,  W_MIS,     64'd0,     MIS_ERR};
    vecs[10] = '{"ld_10_b",   1'b0, 64'h10,  64'd0,     W10_FINAL, 1'b0};
    vecs[11] = '{"st_hi",     1'b1, 64'h8000_0000_0000_0010, 64'h1234, 64'd0, 1'b1};
    vecs[12] = '{"ld_10_c",   1'b0, 64'h10,  64'd0,     W10_FINAL, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.req_ready",  64'(req_ready),  64'd1);
    chk("reset.resp_valid", 64'(resp_valid), 64'd0);
    chk("reset.stall",      64'(stall),      64'd0);
    chk("reset.rdata",      resp_rdata,      64'd0);
    chk("reset.err",        64'(resp_err),   64'd0);

    for (int v = 0; v < NVEC; v++) begin
      do_txn(vecs[v].name, vecs[v].we, vecs[v].addr, vecs[v].wdata,
             vecs[v].exp_rdata, vecs[v].exp_err);
    end

    // Hold the response for 5 cycles while a stray store is offered.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 64'h10;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL hold.timeout: resp_valid never rose within 40 cycles");
    end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 64'h30;
      req_wdata = 64'h77;
      @(posedge clk);
      @(negedge clk);
      chk("hold.resp_valid", 64'(resp_valid), 64'd1);
      chk("hold.rdata",      resp_rdata,      W10_FINAL);
      chk("hold.req_ready",  64'(req_ready),  64'd0);
      chk("hold.stall",      64'(stall),      64'd1);
      $display("txn hold cycle %0d resp_valid=%0b rdata=0x%016h", c, resp_valid, resp_rdata);
    end
    req_valid  = 1'b0;
    req_we     = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold.release_resp_valid", 64'(resp_valid), 64'd0);
    chk("hold.release_req_ready",  64'(req_ready),  64'd1);
    do_txn("ld_30_ignored", 1'b0, 64'h30, 64'd0, 64'd0, 1'b0);

    // Reset during WAIT aborts a store and clears the array.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 64'h20;
    req_wdata  = 64'h55;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait.req_ready",  64'(req_ready),  64'd1);
    chk("rst_wait.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_wait.stall",      64'(stall),      64'd0);
    chk("rst_wait.rdata",      resp_rdata,      64'd0);
    $display("txn rst_in_wait req_ready=%0b stall=%0b", req_ready, stall);
    do_txn("ld_20_after_rst", 1'b0, 64'h20,  64'd0, 64'd0, 1'b0);
    do_txn("ld_10_after_rst", 1'b0, 64'h10,  64'd0, 64'd0, 1'b0);
    do_txn("ld_3f8_after_rst", 1'b0, 64'h3F8, 64'd0, 64'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
